// File: rtl/zion_bc_rr_burst_arbiter.sv
// zion_bc_rr_burst_arbiter
//   Round-robin burst arbiter. It shares one downstream stage among NUM_REQ
//   requesters. A grant lasts for a whole burst. The burst ends on a
//   transferred iLast, when the granted requester drops iReq, or when
//   MAX_BURST beats have transferred. One IDLE cycle always separates bursts.
// Ports
//   clk, rst  : clock and synchronous active-high reset
//   iReq      : per-requester request/valid
//   iLast     : per-requester last-beat flag, only acted on with a transfer
//   iDat      : packed requester data, requester k at [k*DW +: DW]
//   oRdy      : per-requester ready, one-hot on the granted index or zero
//   oVld/oDat : downstream valid/data (combinational pass-through of grant)
//   oSrc      : index of the granted requester
//   iRdy      : downstream ready
module zion_bc_rr_burst_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    iReq,
  input  logic [NUM_REQ-1:0]    iLast,
  input  logic [NUM_REQ*DW-1:0] iDat,
  output logic [NUM_REQ-1:0]    oRdy,
  output logic                  oVld,
  output logic [DW-1:0]         oDat,
  output logic [IDX_W-1:0]      oSrc,
  input  logic                  iRdy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  int unsigned       idx;
  logic [DW-1:0]     dat_sel;
  logic [IDX_W-1:0]  ptr_inc;
  logic              req_g;
  logic              last_g;
  logic              xfer;

  // Search for the first requester, starting at ptr and wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(ptr_q) + i) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && iReq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    dat_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        dat_sel = iDat[k*DW +: DW];
      end
    end
  end

  assign ptr_inc = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
  assign req_g   = iReq[gnt_q];
  assign last_g  = iLast[gnt_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    oVld    = 1'b0;
    oRdy    = '0;
    oDat    = '0;
    oSrc    = gnt_q;
    xfer    = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        oVld        = req_g;
        oDat        = dat_sel;
        oRdy[gnt_q] = iRdy;
        xfer        = req_g & iRdy;
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!req_g || (xfer && (last_g || cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d = IDLE;
          ptr_d   = ptr_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle abandons any burst, so it must not offer a handshake.
    if (rst) begin
      oVld = 1'b0;
      oRdy = '0;
      oDat = '0;
    end
  end

endmodule
